pattern_detector: RTL and testbench

PATTERN_DETECTOR -- requirements
Module: pattern_detector

---
 rtl/pattern_detector_if.sv | 30 +++
 rtl/pattern_detector.sv | 91 +++++++++
 tb/tb_pattern_detector.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pattern_detector_if.sv
// rtl/pattern_detector_if.sv - serial data, configuration and status bundle for pattern_detector
interface pattern_detector_if #(
  parameter int MAX_LEN = 16,
  parameter int CW      = 8
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic               DATA_IN;
  logic               DATA_VALID;
  logic               OVERLAP_EN;
  logic               CFG_LOAD;
  logic [MAX_LEN-1:0] CFG_PATTERN;
  logic [LW-1:0]      CFG_LEN;
  logic               CNT_CLR;
  logic               SEQ_FOUND;
  logic [CW-1:0]      MATCH_COUNT;
  logic               CFG_ERR;

  // Stimulus/controller side
  modport master (
    output DATA_IN, DATA_VALID, OVERLAP_EN, CFG_LOAD, CFG_PATTERN, CFG_LEN, CNT_CLR,
    input  SEQ_FOUND, MATCH_COUNT, CFG_ERR
  );

  // Detector side
  modport slave (
    input  DATA_IN, DATA_VALID, OVERLAP_EN, CFG_LOAD, CFG_PATTERN, CFG_LEN, CNT_CLR,
    output SEQ_FOUND, MATCH_COUNT, CFG_ERR
  );
endinterface

// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - configurable serial bit-pattern detector with saturating match counter
module pattern_detector #(
  parameter int          MAX_LEN     = 16,
  parameter int          CW          = 8,
  parameter logic [31:0] DEFAULT_PAT = 32'b110100,
  parameter int          DEFAULT_LEN = 6
) (
  input logic              clk,
  input logic              rst,
  pattern_detector_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  logic [MAX_LEN-1:0] history;
  logic [LW-1:0]      fill;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               seq_found_q;
  logic [CW-1:0]      match_count_q;
  logic               cfg_err_q;

  logic [MAX_LEN-1:0] hist_next;
  logic [LW-1:0]      fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  // Next history/fill for an accepted bit and the match decision on that updated view.
  // A zero length means detection is disabled; a load edge never matches because it drops the bit.
  always_comb begin
    hist_next = {history[MAX_LEN-2:0], bus.DATA_IN};
    fill_inc  = (fill == LEN_MAX) ? fill : fill + LW'(1);
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit = bus.DATA_VALID && !bus.CFG_LOAD && (len_q != '0) && (fill_inc >= len_q) &&
          (((hist_next ^ pat_q) & len_mask) == '0);
  end

  // Configuration, history/fill tracking and the one-cycle match pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history     <= '0;
      fill        <= '0;
      seq_found_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      pat_q       <= DEFAULT_PAT[MAX_LEN-1:0];
      len_q       <= LW'(DEFAULT_LEN);
    end else begin
      seq_found_q <= hit;
      if (bus.CFG_LOAD) begin
        pat_q <= bus.CFG_PATTERN;
        fill  <= '0;
        if (bus.CFG_LEN == '0) begin
          len_q     <= '0;
          cfg_err_q <= 1'b1;
        end else if (bus.CFG_LEN > LEN_MAX) begin
          len_q     <= LEN_MAX;
          cfg_err_q <= 1'b1;
        end else begin
          len_q     <= bus.CFG_LEN;
          cfg_err_q <= 1'b0;
        end
      end else if (bus.DATA_VALID) begin
        history <= hist_next;
        // Non-overlapping mode restarts the fill so the next match needs a fresh window.
        fill    <= (hit && !bus.OVERLAP_EN) ? '0 : fill_inc;
      end
    end
  end

  // Saturating match counter; a clear coinciding with a match counts that match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count_q <= '0;
    end else if (hit) begin
      if (bus.CNT_CLR) begin
        match_count_q <= CW'(1);
      end else if (match_count_q != {CW{1'b1}}) begin
        match_count_q <= match_count_q + CW'(1);
      end
    end else if (bus.CNT_CLR) begin
      match_count_q <= '0;
    end
  end

  assign bus.SEQ_FOUND   = seq_found_q;
  assign bus.MATCH_COUNT = match_count_q;
  assign bus.CFG_ERR     = cfg_err_q;
endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - directed scoreboard bench for pattern_detector
module tb_pattern_detector;
  localparam int MAX_LEN = 16;
  localparam int CW      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  pattern_detector_if #(.MAX_LEN(MAX_LEN), .CW(CW)) bus ();

  pattern_detector #(.MAX_LEN(MAX_LEN), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: expected pulse goes into the scoreboard now, is popped once the edge has happened.
  task automatic tick(input string tag, input logic exp_found);
    exp_q.push_back(exp_found);
    @(posedge clk);
    #1;
    chk(tag, {31'b0, bus.SEQ_FOUND}, {31'b0, exp_q.pop_front()});
  endtask

  task automatic send(input string tag, input logic b, input logic exp_found);
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = b;
    tick(tag, exp_found);
    bus.DATA_VALID = 1'b0;
  endtask

  task automatic idle(input string tag);
    bus.DATA_VALID = 1'b0;
    tick(tag, 1'b0);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [4:0] len);
    bus.CFG_LOAD    = 1'b1;
    bus.CFG_PATTERN = pat;
    bus.CFG_LEN     = len;
    tick("load_edge", 1'b0);
    bus.CFG_LOAD    = 1'b0;
  endtask

  task automatic clr_cnt();
    bus.CNT_CLR = 1'b1;
    idle("clr_edge");
    bus.CNT_CLR = 1'b0;
  endtask

  task automatic send_legacy(input string tag);
    logic [5:0] s;
    s = 6'b110100;
    for (int i = 5; i >= 0; i--) send(tag, s[i], i == 0);
  endtask

  initial begin
    logic [15:0] w;
    bus.DATA_IN = 1'b0; bus.DATA_VALID = 1'b0; bus.OVERLAP_EN = 1'b0;
    bus.CFG_LOAD = 1'b0; bus.CFG_PATTERN = '0; bus.CFG_LEN = '0; bus.CNT_CLR = 1'b0;

    #12;
    chk("rst_found", {31'b0, bus.SEQ_FOUND}, 32'd0);
    chk("rst_count", {28'b0, bus.MATCH_COUNT}, 32'd0);
    chk("rst_err",   {31'b0, bus.CFG_ERR}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Default pattern, legacy stream, then a restart giving a second match.
    send_legacy("legacy1");
    idle("legacy_after");
    chk("legacy_count1", {28'b0, bus.MATCH_COUNT}, 32'd1);
    send_legacy("legacy2");
    chk("legacy_count2", {28'b0, bus.MATCH_COUNT}, 32'd2);

    // Gaps of invalid cycles between bits 4 and 5.
    send("gap_b1", 1'b1, 1'b0); send("gap_b2", 1'b1, 1'b0);
    send("gap_b3", 1'b0, 1'b0); send("gap_b4", 1'b1, 1'b0);
    idle("gap_idle"); idle("gap_idle"); idle("gap_idle");
    send("gap_b5", 1'b0, 1'b0); send("gap_b6", 1'b0, 1'b1);
    chk("gap_count", {28'b0, bus.MATCH_COUNT}, 32'd3);
    clr_cnt();
    chk("clr_count", {28'b0, bus.MATCH_COUNT}, 32'd0);

    // Pattern 101, overlapping.
    bus.OVERLAP_EN = 1'b1;
    load(16'b101, 5'd3);
    chk("load3_err", {31'b0, bus.CFG_ERR}, 32'd0);
    send("ov_b1", 1'b1, 1'b0); send("ov_b2", 1'b0, 1'b0); send("ov_b3", 1'b1, 1'b1);
    send("ov_b4", 1'b0, 1'b0); send("ov_b5", 1'b1, 1'b1);
    chk("ov_count", {28'b0, bus.MATCH_COUNT}, 32'd2);
    clr_cnt();

    // Pattern 101, non-overlapping.
    bus.OVERLAP_EN = 1'b0;
    load(16'b101, 5'd3);
    send("nov_b1", 1'b1, 1'b0); send("nov_b2", 1'b0, 1'b0); send("nov_b3", 1'b1, 1'b1);
    send("nov_b4", 1'b0, 1'b0); send("nov_b5", 1'b1, 1'b0);
    chk("nov_count", {28'b0, bus.MATCH_COUNT}, 32'd1);

    // A data bit on the load edge is dropped and does not count toward fill.
    bus.DATA_VALID = 1'b1; bus.DATA_IN = 1'b1;
    load(16'b101, 5'd3);
    bus.DATA_VALID = 1'b0;
    send("drop_b1", 1'b0, 1'b0); send("drop_b2", 1'b1, 1'b0);
    send("drop_b3", 1'b0, 1'b0); send("drop_b4", 1'b1, 1'b1);
    chk("drop_count", {28'b0, bus.MATCH_COUNT}, 32'd2);

    // Saturation at 15, then clear on a match edge gives 1.
    clr_cnt();
    bus.OVERLAP_EN = 1'b1;
    load(16'b101, 5'd3);
    send("sat_b1", 1'b1, 1'b0); send("sat_b2", 1'b0, 1'b0); send("sat_b3", 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      send("sat_z", 1'b0, 1'b0);
      send("sat_o", 1'b1, 1'b1);
    end
    chk("sat_count", {28'b0, bus.MATCH_COUNT}, 32'd15);
    send("sat_z2", 1'b0, 1'b0);
    bus.CNT_CLR = 1'b1;
    send("sat_clr_match", 1'b1, 1'b1);
    bus.CNT_CLR = 1'b0;
    chk("clr_on_match", {28'b0, bus.MATCH_COUNT}, 32'd1);

    // Length 0 disables detection.
    bus.OVERLAP_EN = 1'b0;
    load(16'h0000, 5'd0);
    chk("len0_err", {31'b0, bus.CFG_ERR}, 32'd1);
    for (int i = 0; i < 8; i++) send("len0_none", i[0], 1'b0);

    // Over-long length clamps to 16-bit matching.
    load(16'hA5C3, 5'd31);
    chk("len31_err", {31'b0, bus.CFG_ERR}, 32'd1);
    w = 16'hA5C3;
    for (int i = 15; i >= 0; i--) send("len16_bits", w[i], i == 0);
    chk("len16_count", {28'b0, bus.MATCH_COUNT}, 32'd2);

    // Valid length 4; pattern bits above the length are ignored.
    load(16'hFFF9, 5'd4);
    chk("len4_err", {31'b0, bus.CFG_ERR}, 32'd0);
    send("len4_b1", 1'b1, 1'b0); send("len4_b2", 1'b0, 1'b0);
    send("len4_b3", 1'b0, 1'b0); send("len4_b4", 1'b1, 1'b1);
    chk("len4_count", {28'b0, bus.MATCH_COUNT}, 32'd3);

    // Asynchronous reset clears everything between edges and restores defaults.
    load(16'h0000, 5'd0);
    rst = 1'b1;
    #1;
    chk("arst_count", {28'b0, bus.MATCH_COUNT}, 32'd0);
    chk("arst_err",   {31'b0, bus.CFG_ERR}, 32'd0);
    rst = 1'b0;
    send_legacy("deflt_again");
    rst = 1'b1;
    #1;
    chk("arst_found", {31'b0, bus.SEQ_FOUND}, 32'd0);
    chk("arst_count2", {28'b0, bus.MATCH_COUNT}, 32'd0);
    rst = 1'b0;

    // Partial progress is lost on reset mid-sequence.
    send("part_b1", 1'b1, 1'b0); send("part_b2", 1'b1, 1'b0);
    send("part_b3", 1'b0, 1'b0); send("part_b4", 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_found", {31'b0, bus.SEQ_FOUND}, 32'd0);
    rst = 1'b0;
    send("post_b1", 1'b0, 1'b0); send("post_b2", 1'b0, 1'b0);
    send_legacy("post_full");
    chk("post_count", {28'b0, bus.MATCH_COUNT}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
